// File: rtl/operand_entry_fsm.sv
// Operand entry for the ripple adder: debounced keys load A, B/cin, then latch {cout,sum}.
// Latency: key press accepted DEBOUNCE_CYCLES+2 cycles after raw rise; result latched one cycle after ADD.
// Backpressure: none; keys are one-shot events and are dropped when the FSM cannot use them.
module operand_entry_fsm #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             cin_sw,
    input  logic             key_enter,
    input  logic             key_clear,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             cin_out,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    output logic [1:0]       state_out
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam int            ENTER    = 0;
    localparam int            CLEAR    = 1;

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        ADD    = 2'b10,
        SHOW   = 2'b11
    } state_t;

    state_t        state;
    logic [1:0]    key_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    accepted;
    logic [1:0]    press;
    logic [CW-1:0] cnt [2];

    assign key_raw   = {key_clear, key_enter};
    assign state_out = state;

    // Both keys share the same synchronizer/debounce path; a pulse only on an accepted rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            accepted <= '0;
            press    <= '0;
            for (int k = 0; k < 2; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int k = 0; k < 2; k++) begin
                press[k] <= 1'b0;
                if (sync2[k] != accepted[k]) begin
                    if (cnt[k] == CNT_LAST) begin
                        accepted[k] <= sync2[k];
                        cnt[k]      <= '0;
                        press[k]    <= sync2[k];
                    end else begin
                        cnt[k] <= cnt[k] + CW'(1);
                    end
                end else begin
                    cnt[k] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOAD_A;
            a_out        <= '0;
            b_out        <= '0;
            cin_out      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else if (press[CLEAR]) begin
            state        <= LOAD_A;
            a_out        <= '0;
            b_out        <= '0;
            cin_out      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (press[ENTER]) begin
                        a_out <= sw;
                        state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press[ENTER]) begin
                        b_out   <= sw;
                        cin_out <= cin_sw;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    result       <= {cout_in, sum_in};
                    result_valid <= 1'b1;
                    state        <= SHOW;
                end
                SHOW: begin
                    // Accumulate: sum becomes next A, carry bit is dropped.
                    if (press[ENTER]) begin
                        a_out        <= result[WIDTH-1:0];
                        result_valid <= 1'b0;
                        state        <= LOAD_B;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

endmodule

// File: doc/operand_entry_fsm.md
Name: operand_entry_fsm

Overview:
- Upstream operand-entry stage for the 4-bit ripple adder datapath on the board top level.
- Captures A, B and carry-in from slide switches on debounced key presses, and drives them to the adder.
- Latches the adder's sum/carry-out into a result register that feeds the hex display translators.
- Supports chained accumulation: the previous result becomes the next A operand.

Parameters:
- WIDTH, 4, operand width in bits; matches the adder width.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles needed to accept a key edge (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw  input  WIDTH  raw operand switches; sampled only on an accepted enter press.
- cin_sw  input  1  raw carry-in switch; sampled together with B.
- key_enter  input  1  raw, asynchronous, bouncy enter key; active-high.
- key_clear  input  1  raw, asynchronous, bouncy clear key; active-high.
- sum_in  input  WIDTH  sum returned from the adder.
- cout_in  input  1  carry-out returned from the adder.
- a_out  output  WIDTH  registered A operand to the adder.
- b_out  output  WIDTH  registered B operand to the adder.
- cin_out  output  1  registered carry-in to the adder.
- result  output  WIDTH+1  latched {cout_in, sum_in}.
- result_valid  output  1  high while result holds a fresh sum.
- state_out  output  2  current FSM state encoding, for LEDs.

Behaviour:
- Reset: async; all outputs 0, state LOAD_A, synchronizers, debounce counters and pulse registers cleared. Reset mid-operation discards any partial entry.
- Key conditioning, one identical instance per key:
  - 2-flop synchronizer, then a debounce counter.
  - The counter increments while the synchronized level differs from the accepted level; otherwise it resets to 0.
  - When the counter reaches DEBOUNCE_CYCLES, the accepted level flips and the counter resets.
  - A 1-cycle press pulse fires on an accepted 0->1 flip only.
  - Latency: raw rise held stable -> pulse exactly DEBOUNCE_CYCLES+2 cycles later.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
  - A held key produces one pulse.
  - Release must also be stable DEBOUNCE_CYCLES cycles before the next press can be accepted.
- FSM, state_out encoding in brackets:
  - LOAD_A (00): on enter pulse, a_out<=sw; go to LOAD_B.
  - LOAD_B (01): on enter pulse, b_out<=sw and cin_out<=cin_sw; go to ADD.
  - ADD (10): unconditional single settle cycle; the adder is combinational and settles within the cycle. Next edge: result<={cout_in,sum_in}, result_valid<=1; go to SHOW.
  - SHOW (11): result held. On enter pulse (accumulate): a_out<=result[WIDTH-1:0], result_valid<=0; go to LOAD_B. Result keeps its old value until overwritten.
- Clear pulse, in any state: a_out, b_out, cin_out, result, result_valid <= 0; go to LOAD_A.
- Clear pulse and enter pulse in the same cycle: clear wins and enter is dropped.
- Enter pulse during ADD: ignored.
- Arithmetic: the block does no addition itself. result width is WIDTH+1, so 15+15+1=31 (5'b11111) is representable with no wrap. In accumulate mode the carry bit is dropped when fed back to A.
- sw and cin_sw are not synchronized; they are required static when enter is pressed.

Test Plan (bench uses DEBOUNCE_CYCLES=4 and models the adder as sum_in/cout_in = a_out+b_out+cin_out):
- Reset mid-entry: a_out=5, state LOAD_B, assert rst asynchronously between clock edges -> all outputs 0 immediately, state_out=00.
- Basic add: sw=7 enter, sw=8 cin_sw=0 enter -> a_out=7, b_out=8, then result=5'b01111, result_valid=1, state_out=11 one cycle after leaving ADD.
- Max carry: A=15, B=15, cin=1 -> result=5'b11111.
- Accumulate: after 7+8=15, enter in SHOW with sw=1 carrying B -> a_out=15, b_out=1, result=5'b10000. Also check accumulate with carry drop: result 5'b10000 fed back gives a_out=0.
- Debounce: 3-cycle enter glitch -> no state change. Key held 50 cycles -> exactly one pulse. Stable press -> pulse at exactly cycle 6 after raw rise.
- Simultaneous clear and enter accepted in the same cycle while in LOAD_B -> state LOAD_A, b_out stays 0, a_out cleared.
